sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port (23-bit word address, 32-bit data, req/ack/valid handshake) between several requesters in the Tecmo core.
- Requesters are the ROM download writer and the CPU, tile and sprite ROM fetchers.
- Sits between those requesters and the sdram controller in clk_sys at 96 MHz.
- Keeps one transaction outstanding at a time and routes ack and valid back to the granted requester only.

Parameters:
- NUM_PORTS, 4, number of requester ports; port 0 is the download port.
- ADDR_WIDTH, 23, SDRAM word address width.
- DATA_WIDTH, 32, SDRAM data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- port_addr  in  NUM_PORTS*ADDR_WIDTH  packed per-port addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- port_data  in  NUM_PORTS*DATA_WIDTH  packed per-port write data.
- port_we  in  NUM_PORTS  per-port write enable.
- port_req  in  NUM_PORTS  per-port request level; held high until that port's ack.
- port_ack  out  NUM_PORTS  one-hot, 1-cycle pulse when the port's request is accepted by SDRAM.
- port_valid  out  NUM_PORTS  one-hot, 1-cycle pulse when the port's read data is on port_q.
- port_q  out  DATA_WIDTH  read data, shared by all ports; qualified by port_valid.
- sdram_addr  out  ADDR_WIDTH  to controller.
- sdram_data  out  DATA_WIDTH  to controller.
- sdram_we  out  1  to controller.
- sdram_req  out  1  to controller.
- sdram_ack  in  1  controller has accepted the command (1-cycle pulse).
- sdram_valid  in  1  controller read data is valid (1-cycle pulse; reads only).
- sdram_q  in  DATA_WIDTH  controller read data.
- busy  out  1  high whenever state is not IDLE.
- grant  out  $clog2(NUM_PORTS)  index of the granted port, registered.

Behaviour:
- Reset values: state IDLE; sdram_req 0; sdram_addr 0; sdram_data 0; sdram_we 0; grant 0; busy 0. port_ack and port_valid are 0 because they are decoded from state.
- IDLE:
  - If any port_req is high, select a winner by priority (see Optional Feature).
  - Register the winner's addr, data and we into the sdram_* outputs, set grant, assert sdram_req on the next edge, go to WAIT_ACK.
  - sdram_req rises exactly 1 cycle after the winning port_req is sampled.
- WAIT_ACK:
  - Hold sdram_req, addr, data, we and grant stable.
  - On sdram_ack: port_ack[grant] = 1 combinationally in that same cycle; sdram_req is cleared on the edge.
  - Next state: IDLE if the command was a write; WAIT_VALID if it was a read.
- WAIT_VALID:
  - On sdram_valid: port_valid[grant] = 1 combinationally; port_q = sdram_q (port_q always passes sdram_q through). Go to IDLE.
- Requester contract: port_req drops on the edge after port_ack. IDLE therefore sees the updated port_req and issues no duplicate grant.
- The grant is committed at selection. If a requester drops port_req early, the transaction still completes and the ack/valid pulses still occur.
- Changes on ports other than the granted port while busy are ignored.
- sdram_ack or sdram_valid arriving in IDLE, or sdram_valid arriving in WAIT_ACK, is ignored. No port pulse is generated.
- Reset asserted mid-transaction: the next edge forces IDLE and sdram_req 0. A late sdram_valid is then discarded.
- Back-to-back: after a read completes, the next grant may be issued in the IDLE cycle that immediately follows. Minimum spacing is 1 IDLE cycle between transactions.
- Out-of-range grant values are unreachable. When NUM_PORTS is not a power of two, priority logic only considers indices below NUM_PORTS.

Optional Feature:
- Macro SDRAM_ARB_ROUND_ROBIN_EN.
- Without it: fixed priority; the lowest index wins, so port 0 (download) always wins.
- With it:
  - Port 0 still has absolute priority whenever port_req[0] is high.
  - Ports 1..NUM_PORTS-1 rotate: search starts at the port after the last granted non-zero port, wrapping from NUM_PORTS-1 back to 1.
  - The rotation pointer resets to port NUM_PORTS-1, so port 1 searches first after reset.
  - The pointer updates only when a non-zero port is granted.

Test Plan:
- Single read: port 2 req, addr 0x012345 -> sdram_req high 1 cycle later with sdram_addr 0x012345, sdram_we 0. On ack: port_ack = 4'b0100. On valid with q 0xDEADBEEF: port_valid = 4'b0100, port_q 0xDEADBEEF, busy falls.
- Write: port 0 req, we 1, data 0xA5A5A5A5 -> sdram_data 0xA5A5A5A5, sdram_we 1. On ack: port_ack = 4'b0001 and return to IDLE with no valid expected.
- Contention: ports 1, 2 and 3 requesting continuously (each re-requests after completion), fixed priority -> grant sequence 1,1,1. With SDRAM_ARB_ROUND_ROBIN_EN -> grant sequence 1,2,3,1.
- Download override, with the macro defined: ports 0 and 3 both requesting -> grant 0 first. Port 3 is granted after port 0 drops req.
- Spurious handshakes: sdram_valid pulsed in IDLE and sdram_valid pulsed in WAIT_ACK -> port_valid stays 0 and state is unchanged.
- Reset mid-read: reset in WAIT_VALID -> sdram_req 0, busy 0 the next cycle. A following sdram_valid produces no port_valid.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM controller buses around the SDRAM arbiter.
// master is the arbiter's view; slave is the surrounding system's view.
interface sdram_arbiter_if #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] port_data;
   logic [NUM_PORTS-1:0]            port_we;
   logic [NUM_PORTS-1:0]            port_req;
   logic [NUM_PORTS-1:0]            port_ack;
   logic [NUM_PORTS-1:0]            port_valid;
   logic [DATA_WIDTH-1:0]           port_q;
   logic [ADDR_WIDTH-1:0]           sdram_addr;
   logic [DATA_WIDTH-1:0]           sdram_data;
   logic                            sdram_we;
   logic                            sdram_req;
   logic                            sdram_ack;
   logic                            sdram_valid;
   logic [DATA_WIDTH-1:0]           sdram_q;

   modport master (
      input  port_addr, port_data, port_we, port_req,
      input  sdram_ack, sdram_valid, sdram_q,
      output port_ack, port_valid, port_q,
      output sdram_addr, sdram_data, sdram_we, sdram_req
   );

   modport slave (
      output port_addr, port_data, port_we, port_req,
      output sdram_ack, sdram_valid, sdram_q,
      input  port_ack, port_valid, port_q,
      input  sdram_addr, sdram_data, sdram_we, sdram_req
   );
endinterface

// File: rtl/sdram_arbiter.sv
// One-outstanding-transaction arbiter in front of the SDRAM controller.
// Define SDRAM_ARB_ROUND_ROBIN_EN to rotate ports 1..N-1 (port 0 stays on top).
module sdram_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   sdram_arbiter_if.master              bus,
   output logic                         busy,
   output logic [$clog2(NUM_PORTS)-1:0] grant
);
   localparam int GW = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_VALID} state_t;

   state_t                state, nxt;
   logic [GW-1:0]         win, grant_q;
   logic                  any;
   logic [ADDR_WIDTH-1:0] sel_addr, addr_q;
   logic [DATA_WIDTH-1:0] sel_data, data_q;
   logic                  sel_we, we_q, req_q;
   logic [NUM_PORTS-1:0]  gnt_vec;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   logic [GW-1:0]         rr_ptr;
   logic                  found;
`endif

   always_comb begin
      win = '0;
      any = |bus.port_req;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      found = 1'b0;
      // first pass: ports after the last grant; second pass wraps to 1
      for (int j = 1; j < NUM_PORTS; j++) begin
         if (!found && bus.port_req[j] && GW'(j) > rr_ptr) begin
            win   = GW'(j);
            found = 1'b1;
         end
      end
      for (int j = 1; j < NUM_PORTS; j++) begin
         if (!found && bus.port_req[j]) begin
            win   = GW'(j);
            found = 1'b1;
         end
      end
      if (bus.port_req[0]) win = '0;
`else
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
         if (bus.port_req[j]) win = GW'(j);
      end
`endif
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_we   = 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (win == GW'(j)) begin
            sel_addr = bus.port_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = bus.port_data[j*DATA_WIDTH +: DATA_WIDTH];
            sel_we   = bus.port_we[j];
         end
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:       if (any) nxt = WAIT_ACK;
         WAIT_ACK:   if (bus.sdram_ack) nxt = we_q ? IDLE : WAIT_VALID;
         WAIT_VALID: if (bus.sdram_valid) nxt = IDLE;
         default:    nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         grant_q <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         rr_ptr  <= GW'(NUM_PORTS - 1);
`endif
      end else begin
         state <= nxt;
         if (state == IDLE && any) begin
            addr_q  <= sel_addr;
            data_q  <= sel_data;
            we_q    <= sel_we;
            grant_q <= win;
            req_q   <= 1'b1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            if (win != '0) rr_ptr <= win;
`endif
         end else if (state == WAIT_ACK && bus.sdram_ack) begin
            req_q <= 1'b0;
         end
      end
   end

   assign gnt_vec        = NUM_PORTS'(1) << grant_q;
   assign bus.port_ack   = (state == WAIT_ACK && bus.sdram_ack) ? gnt_vec : '0;
   assign bus.port_valid = (state == WAIT_VALID && bus.sdram_valid) ? gnt_vec : '0;
   assign bus.port_q     = bus.sdram_q;
   assign bus.sdram_addr = addr_q;
   assign bus.sdram_data = data_q;
   assign bus.sdram_we   = we_q;
   assign bus.sdram_req  = req_q;
   assign busy           = (state != IDLE);
   assign grant          = grant_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized bench for sdram_arbiter with a priority model.
// The bench plays both the requesters and the SDRAM controller.
module tb_sdram_arbiter;
   localparam int NP = 4;
   localparam int AW = 23;
   localparam int DW = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic       busy;
   logic [1:0] grant;

   sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master),
      .busy  (busy),
      .grant (grant)
   );

   always #5 clk = ~clk;

   int            npass = 0;
   int            ntot  = 0;
   int            last;
   logic [AW-1:0] pa [NP];
   logic [DW-1:0] pd [NP];
   logic          pw [NP];
   logic [NP-1:0] req_v;
   int            g, lat;
   int            seq [4];
   int            exp_seq [4];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic apply();
      for (int i = 0; i < NP; i++) begin
         bus.port_addr[i*AW +: AW] = pa[i];
         bus.port_data[i*DW +: DW] = pd[i];
         bus.port_we[i]            = pw[i];
      end
      bus.port_req = req_v;
   endtask

   // Download port first; others by lowest index or rotating after last.
   function automatic int pick(input logic [NP-1:0] r, input int lst);
      if (r[0]) return 0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NP - 1; k++) begin
         int p;
         p = (lst + k) % (NP - 1) + 1;
         if (r[p]) return p;
      end
`else
      for (int p = 1; p < NP; p++) if (r[p]) return p;
`endif
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      last  = NP - 1;
   endtask

   task automatic txn(input int ad, input int vd, input logic [DW-1:0] q,
                      input bit spur, output int gi, output int l);
      logic [NP-1:0] snap;
      logic [NP-1:0] oh;
      int            e;
      gi   = -1;
      l    = 0;
      snap = bus.port_req;
      step();
      while (!bus.sdram_req && l < 8) begin
         snap = bus.port_req;
         step();
         l++;
      end
      chk("req_rise", bus.sdram_req, 1);
      if (!bus.sdram_req) return;
      e = pick(snap, last);
      if (e > 0) last = e;
      gi = e;
      oh = '0;
      if (e >= 0) oh[e] = 1'b1;
      chk("grant", grant, e);
      chk("addr", bus.sdram_addr, pa[e]);
      chk("data", bus.sdram_data, pd[e]);
      chk("we", bus.sdram_we, pw[e]);
      chk("busy_on", busy, 1);
      repeat (ad) begin
         if (spur) bus.sdram_valid = 1'b1;
         #1;
         chk("ack_early", bus.port_ack, 0);
         chk("valid_wack", bus.port_valid, 0);
         step();
         bus.sdram_valid = 1'b0;
         spur = 1'b0;
         chk("req_hold", bus.sdram_req, 1);
      end
      bus.sdram_ack = 1'b1;
      #1;
      chk("port_ack", bus.port_ack, oh);
      step();
      bus.sdram_ack = 1'b0;
      req_v[e] = 1'b0;
      apply();
      chk("req_clr", bus.sdram_req, 0);
      if (pw[e]) begin
         chk("wr_idle", busy, 0);
      end else begin
         chk("rd_busy", busy, 1);
         repeat (vd) begin
            step();
            chk("valid_early", bus.port_valid, 0);
         end
         bus.sdram_valid = 1'b1;
         bus.sdram_q     = q;
         #1;
         chk("port_valid", bus.port_valid, oh);
         chk("port_q", bus.port_q, q);
         step();
         bus.sdram_valid = 1'b0;
         chk("rd_idle", busy, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < NP; i++) begin
         pa[i] = '0;
         pd[i] = '0;
         pw[i] = 1'b0;
      end
      req_v           = '0;
      apply();
      bus.sdram_ack   = 1'b0;
      bus.sdram_valid = 1'b0;
      bus.sdram_q     = '0;
      reset           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      last  = NP - 1;
      chk("rst_req", bus.sdram_req, 0);
      chk("rst_addr", bus.sdram_addr, 0);
      chk("rst_data", bus.sdram_data, 0);
      chk("rst_we", bus.sdram_we, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", bus.port_ack, 0);
      chk("rst_valid", bus.port_valid, 0);

      // single read from port 2
      pa[2] = 23'h012345;
      pw[2] = 1'b0;
      req_v = 4'b0100;
      apply();
      txn(0, 1, 32'hDEADBEEF, 1'b0, g, lat);
      chk("rd_lat", lat, 0);
      chk("rd_port", g, 2);

      // write from download port
      pd[0] = 32'hA5A5A5A5;
      pw[0] = 1'b1;
      req_v = 4'b0001;
      apply();
      txn(1, 0, '0, 1'b1, g, lat);
      chk("wr_port", g, 0);

      // spurious handshakes in IDLE
      step();
      bus.sdram_valid = 1'b1;
      bus.sdram_ack   = 1'b1;
      #1;
      chk("spur_valid", bus.port_valid, 0);
      chk("spur_ack", bus.port_ack, 0);
      step();
      bus.sdram_valid = 1'b0;
      bus.sdram_ack   = 1'b0;
      chk("spur_busy", busy, 0);
      chk("spur_req", bus.sdram_req, 0);

      // contention between ports 1..3, each re-requesting
      do_reset();
      for (int i = 1; i < NP; i++) pw[i] = 1'b0;
      req_v = 4'b1110;
      apply();
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      exp_seq = '{1, 2, 3, 1};
`else
      exp_seq = '{1, 1, 1, 1};
`endif
      for (int i = 0; i < 4; i++) begin
         txn(0, 0, $urandom, 1'b0, g, lat);
         seq[i] = g;
         if (g >= 0) req_v[g] = 1'b1;
         apply();
      end
      for (int i = 0; i < 4; i++) chk("cont_seq", seq[i], exp_seq[i]);

      // download override
      req_v = 4'b1001;
      pw[0] = 1'b1;
      pw[3] = 1'b1;
      apply();
      txn(0, 0, '0, 1'b0, g, lat);
      chk("ovr_first", g, 0);
      txn(0, 0, '0, 1'b0, g, lat);
      chk("ovr_second", g, 3);

      // reset during WAIT_VALID
      pw[1] = 1'b0;
      req_v = 4'b0010;
      apply();
      step();
      chk("mr_req", bus.sdram_req, 1);
      bus.sdram_ack = 1'b1;
      step();
      bus.sdram_ack = 1'b0;
      req_v = '0;
      apply();
      chk("mr_wv_busy", busy, 1);
      do_reset();
      chk("mr_req_clr", bus.sdram_req, 0);
      chk("mr_busy_clr", busy, 0);
      bus.sdram_valid = 1'b1;
      #1;
      chk("mr_late_valid", bus.port_valid, 0);
      step();
      bus.sdram_valid = 1'b0;
      chk("mr_idle", busy, 0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NP; i++) begin
            pa[i] = AW'($urandom);
            pd[i] = $urandom;
            pw[i] = 1'($urandom_range(0, 1));
         end
         req_v = NP'($urandom_range(1, 15));
         apply();
         txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             1'($urandom_range(0, 1)), g, lat);
         chk("rnd_lat", lat, 0);
      end
      req_v = '0;
      apply();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
